// File: rtl/load_store_unit.sv
// Load/store unit between a core and a 64-word, single-port data memory.
// It handles byte, half and word access, sign/zero extension, and read-modify-write for SB/SH.
module load_store_unit #(
  parameter int ADDR_BITS = 8
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic [2:0]           Op,
  input  logic [ADDR_BITS-1:0] Addr,
  input  logic [31:0]          StoreData,
  output logic                 Busy,
  output logic                 Done,
  output logic [31:0]          LoadData,
  output logic                 MisalignErr,
  output logic [ADDR_BITS-3:0] MemAddress,
  output logic [31:0]          MemWriteData,
  output logic                 MemoryRead,
  output logic                 MemoryWrite,
  input  logic [31:0]          MemReadData
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RD    = 3'd1;
  localparam logic [2:0] LDRET = 3'd2;
  localparam logic [2:0] MERGE = 3'd3;
  localparam logic [2:0] WR    = 3'd4;

  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LW  = 3'd2;
  localparam logic [2:0] OP_LBU = 3'd3;
  localparam logic [2:0] OP_LHU = 3'd4;
  localparam logic [2:0] OP_SB  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SW  = 3'd7;

  logic [2:0]  state;
  logic [2:0]  opReg;
  logic [1:0]  laneReg;
  logic [15:0] storeReg;
  logic [31:0] writeReg;
  logic        misaligned;
  logic [7:0]  byteSel;
  logic [15:0] halfSel;
  logic [31:0] loadWord;
  logic [31:0] mergedWord;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    misaligned = 1'b0;
    case (Op)
      OP_LH, OP_LHU, OP_SH: misaligned = Addr[0];
      OP_LW, OP_SW:         misaligned = |Addr[1:0];
      default:              misaligned = 1'b0;
    endcase
  end

  always_comb begin
    byteSel = MemReadData[{laneReg, 3'b000} +: 8];
    halfSel = laneReg[1] ? MemReadData[31:16] : MemReadData[15:0];
    case (opReg)
      OP_LB:   loadWord = {{24{byteSel[7]}}, byteSel};
      OP_LH:   loadWord = {{16{halfSel[15]}}, halfSel};
      OP_LBU:  loadWord = {24'd0, byteSel};
      OP_LHU:  loadWord = {16'd0, halfSel};
      default: loadWord = MemReadData;
    endcase
  end

  always_comb begin
    mergedWord = MemReadData;
    if (opReg == OP_SB) mergedWord[{laneReg, 3'b000} +: 8] = storeReg[7:0];
    else if (laneReg[1]) mergedWord[31:16] = storeReg;
    else mergedWord[15:0] = storeReg;
  end

  // The merged word must be ready within the MERGE cycle because memory writes on that negedge.
  assign MemWriteData = (state == MERGE) ? mergedWord : writeReg;
  assign Busy         = (state != IDLE);
  assign MemoryRead   = (state == RD);
  assign MemoryWrite  = ((state == MERGE) || (state == WR)) && !Reset;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= IDLE;
      Done        <= 1'b0;
      MisalignErr <= 1'b0;
      LoadData    <= '0;
      MemAddress  <= '0;
      writeReg    <= '0;
    end else begin
      Done        <= 1'b0;
      MisalignErr <= 1'b0;
      case (state)
        IDLE: if (Start) begin
          if (misaligned) begin
            Done        <= 1'b1;
            MisalignErr <= 1'b1;
          end else begin
            MemAddress <= Addr[ADDR_BITS-1:2];
            if (Op == OP_SW) begin
              writeReg <= StoreData;
              state    <= WR;
            end else begin
              state <= RD;
            end
          end
        end
        RD:    state <= (opReg >= OP_SB) ? MERGE : LDRET;
        LDRET: begin
          LoadData <= loadWord;
          Done     <= 1'b1;
          state    <= IDLE;
        end
        MERGE: begin
          writeReg <= mergedWord;
          Done     <= 1'b1;
          state    <= IDLE;
        end
        WR: begin
          Done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: request-capture registers carry no reset; they are always written before they are used.
  always_ff @(posedge Clock) begin
    if (state == IDLE && Start) begin
      opReg    <= Op;
      laneReg  <= Addr[1:0];
      storeReg <= StoreData[15:0];
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed requests push expected reads, writes and
// completions into queues; negedge monitors pop and compare whatever the DUT presents.
module tb_load_store_unit;

  typedef struct {
    logic [31:0] load;
    logic        err;
    int          cyc;
  } done_t;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
    int          cyc;
  } mem_t;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [2:0]  Op = 3'd0;
  logic [7:0]  Addr = 8'd0;
  logic [31:0] StoreData = 32'd0;
  logic        Busy, Done, MisalignErr, MemoryRead, MemoryWrite;
  logic [31:0] LoadData, MemWriteData;
  logic [31:0] MemReadData;
  logic [5:0]  MemAddress;

  logic [31:0] mem [64];
  int          cyc = 0;
  int          compared = 0;
  int          mismatched = 0;
  logic [31:0] lastLoad = 32'd0;
  done_t       doneQ[$];
  mem_t        rdQ[$];
  mem_t        wrQ[$];

  // Continuous-Start stream: one entry per edge; only flagged entries land on an IDLE edge.
  logic [2:0]  sOp    [7] = '{3'd2, 3'd7, 3'd5, 3'd7, 3'd0, 3'd1, 3'd3};
  logic [7:0]  sAddr  [7] = '{8'h04, 8'hFC, 8'hFD, 8'h10, 8'h00, 8'h05, 8'h0B};
  logic [31:0] sData  [7] = '{32'd0, 32'h12345678, 32'h000000AA, 32'hA5A5A5A5, 32'd0, 32'd0, 32'd0};
  logic        sAcc   [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic        sErr   [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [31:0] sLoad  [7] = '{32'h8899AABB, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'h000000DE};
  logic [31:0] sWdata [7] = '{32'd0, 32'd0, 32'd0, 32'hA5A5A5A5, 32'd0, 32'd0, 32'd0};

  load_store_unit #(.ADDR_BITS(8)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Op(Op), .Addr(Addr),
    .StoreData(StoreData), .Busy(Busy), .Done(Done), .LoadData(LoadData),
    .MisalignErr(MisalignErr), .MemAddress(MemAddress), .MemWriteData(MemWriteData),
    .MemoryRead(MemoryRead), .MemoryWrite(MemoryWrite), .MemReadData(MemReadData)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  always @(posedge Clock) if (MemoryRead) MemReadData <= mem[MemAddress];
  always @(negedge Clock) if (MemoryWrite) mem[MemAddress] <= MemWriteData;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: DUT event with no expectation queued (cycle %0d)", name, cyc);
  endtask

  // Completion monitor.
  always @(negedge Clock) begin
    done_t d;
    if (Done) begin
      if (doneQ.size() == 0) unexpected("done");
      else begin
        d = doneQ.pop_front();
        check("done_cycle", cyc, d.cyc);
        check("load_data", LoadData, d.load);
        check("misalign_err", {31'd0, MisalignErr}, {31'd0, d.err});
        check("busy_at_done", {31'd0, Busy}, 32'd0);
      end
    end
  end

  // Memory-strobe monitor.
  always @(negedge Clock) begin
    mem_t m;
    if (MemoryRead || MemoryWrite) begin
      check("strobe_overlap", {31'd0, MemoryRead & MemoryWrite}, 32'd0);
      check("strobe_while_busy", {31'd0, Busy}, 32'd1);
    end
    if (MemoryRead) begin
      if (rdQ.size() == 0) unexpected("mem_read");
      else begin
        m = rdQ.pop_front();
        check("read_addr", {26'd0, MemAddress}, {26'd0, m.addr});
        check("read_cycle", cyc, m.cyc);
      end
    end
    if (MemoryWrite) begin
      if (wrQ.size() == 0) unexpected("mem_write");
      else begin
        m = wrQ.pop_front();
        check("write_addr", {26'd0, MemAddress}, {26'd0, m.addr});
        check("write_data", MemWriteData, m.data);
        check("write_cycle", cyc, m.cyc);
      end
    end
  end

  // Called just after the accepting edge: queue the strobes and completion the request must produce.
  task automatic expectOp(input logic [2:0] op, input logic [7:0] addr, input logic err,
                          input logic [31:0] expLoad, input logic [31:0] expWdata);
    done_t d;
    mem_t  m;
    m.addr = addr[7:2];
    d.err  = err;
    if (err) begin
      d.cyc = cyc;
    end else if (op == 3'd7) begin
      m.data = expWdata; m.cyc = cyc;
      wrQ.push_back(m);
      d.cyc = cyc + 1;
    end else begin
      m.data = 32'd0; m.cyc = cyc;
      rdQ.push_back(m);
      if (op <= 3'd4) lastLoad = expLoad;
      else begin
        m.data = expWdata; m.cyc = cyc + 1;
        wrQ.push_back(m);
      end
      d.cyc = cyc + 2;
    end
    d.load = lastLoad;
    doneQ.push_back(d);
  endtask

  // Entered and left at a negedge; returning on a Done negedge lets the next request go back-to-back.
  task automatic issue(input logic [2:0] op, input logic [7:0] addr, input logic [31:0] sd,
                       input logic err, input logic [31:0] expLoad, input logic [31:0] expWdata);
    bit seen;
    Start = 1'b1; Op = op; Addr = addr; StoreData = sd;
    @(posedge Clock); #1;
    expectOp(op, addr, err, expLoad, expWdata);
    Start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge Clock);
      seen = Done;
    end
    if (!seen) unexpected("done_timeout");
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] <= 32'd0;
    mem[0] <= 32'hCAFEF00D;
    mem[1] <= 32'h8899AABB;
    mem[2] <= 32'h11223344;
    mem[3] <= 32'hFFFFFFFF;
    MemReadData <= 32'd0;

    repeat (2) @(posedge Clock);
    #1;
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_done", {31'd0, Done}, 32'd0);
    check("rst_misalign", {31'd0, MisalignErr}, 32'd0);
    check("rst_load_data", LoadData, 32'd0);
    check("rst_mem_address", {26'd0, MemAddress}, 32'd0);
    check("rst_mem_wdata", MemWriteData, 32'd0);
    check("rst_strobes", {30'd0, MemoryRead, MemoryWrite}, 32'd0);
    @(negedge Clock);
    Reset = 1'b0;

    //      op    addr   storeData     err   expLoad        expWdata
    issue(3'd0, 8'h07, 32'd0,        1'b0, 32'hFFFFFF88, 32'd0);
    issue(3'd4, 8'h06, 32'd0,        1'b0, 32'h00008899, 32'd0);
    issue(3'd1, 8'h04, 32'd0,        1'b0, 32'hFFFFAABB, 32'd0);
    issue(3'd2, 8'h04, 32'd0,        1'b0, 32'h8899AABB, 32'd0);
    issue(3'd3, 8'h05, 32'd0,        1'b0, 32'h000000AA, 32'd0);
    issue(3'd5, 8'h09, 32'h000000EE, 1'b0, 32'd0,        32'h1122EE44);
    issue(3'd2, 8'h08, 32'd0,        1'b0, 32'h1122EE44, 32'd0);
    issue(3'd6, 8'h0A, 32'h1234CAFE, 1'b0, 32'd0,        32'hCAFEEE44);
    issue(3'd2, 8'h08, 32'd0,        1'b0, 32'hCAFEEE44, 32'd0);
    issue(3'd7, 8'h08, 32'hDEADBEEF, 1'b0, 32'd0,        32'hDEADBEEF);
    issue(3'd2, 8'h06, 32'd0,        1'b1, 32'd0,        32'd0);
    issue(3'd6, 8'h03, 32'h0000FFFF, 1'b1, 32'd0,        32'd0);
    issue(3'd4, 8'h01, 32'd0,        1'b1, 32'd0,        32'd0);
    issue(3'd7, 8'h0A, 32'h55555555, 1'b1, 32'd0,        32'd0);
    issue(3'd5, 8'h0F, 32'h00000012, 1'b0, 32'd0,        32'h12FFFFFF);
    issue(3'd0, 8'h0F, 32'd0,        1'b0, 32'h00000012, 32'd0);

    // Start held high while ops change every cycle.
    Start = 1'b1;
    for (int e = 0; e < 7; e++) begin
      Op = sOp[e]; Addr = sAddr[e]; StoreData = sData[e];
      @(posedge Clock); #1;
      if (sAcc[e]) expectOp(sOp[e], sAddr[e], sErr[e], sLoad[e], sWdata[e]);
      @(negedge Clock);
    end
    Start = 1'b0;
    for (int i = 0; i < 10 && (doneQ.size() != 0 || Busy); i++) @(negedge Clock);
    @(negedge Clock);

    // Reset lands during the MERGE cycle of an SB: nothing may be written or completed.
    Start = 1'b1; Op = 3'd5; Addr = 8'h00; StoreData = 32'h00000055;
    @(posedge Clock); #1;
    begin
      mem_t m;
      m.addr = 6'd0; m.data = 32'd0; m.cyc = cyc;
      rdQ.push_back(m);
    end
    Start = 1'b0;
    @(posedge Clock); #1;
    Reset = 1'b1;
    @(posedge Clock); #1;
    check("abort_busy", {31'd0, Busy}, 32'd0);
    check("abort_done", {31'd0, Done}, 32'd0);
    check("abort_load_data", LoadData, 32'd0);
    lastLoad = 32'd0;
    @(negedge Clock);
    Reset = 1'b0;
    check("abort_mem0", mem[0], 32'hCAFEF00D);
    issue(3'd2, 8'h00, 32'd0, 1'b0, 32'hCAFEF00D, 32'd0);

    repeat (3) @(negedge Clock);
    check("done_queue_drained", doneQ.size(), 32'd0);
    check("read_queue_drained", rdQ.size(), 32'd0);
    check("write_queue_drained", wrQ.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (compared %0d)", compared);
    $fatal(1, "watchdog expired");
  end

endmodule
